instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage directly upstream of the SIMD control unit. Holds the program store (REGN/2 words of 32 bits) and a program counter. On a start request it streams instructions one at a time to the control unit over a valid/ready handshake, stopping at the IDLE opcode or at the end of memory. A host-side write port loads the program while the unit is stopped.

## Interface
- REGN, 512: register-space size; program depth DEPTH = REGN/2.
- IW, 32: instruction width.
- AW, $clog2(REGN/2) = 8: program address width.

- CLK  in  1  single clock, rising edge.
- RSTN  in  1  reset; asynchronous, active-high.
- ONSWT  in  1  run request (GPIO level); a 0→1 transition starts fetching.
- OFFSWT  in  1  abort (GPIO level); forces stop.
- PROG_WE  in  1  program-store write strobe.
- PROG_ADDR  in  AW  program-store write address.
- PROG_DATA  in  IW  program-store write data.
- INSTR  out  IW  instruction to control unit.
- INSTR_VALID  out  1  INSTR is valid.
- INSTR_READY  in  1  control unit accepts INSTR (pulse from its PC-advance logic).
- PC_INS  out  AW  current program counter.
- FETCH_BUSY  out  1  unit is in FETCH or VALID.
- HALTED  out  1  unit stopped on IDLE opcode or end of memory.

## Operation
- States: S_IDLE, S_FETCH, S_VALID, S_HALT.
- ONSWT is registered once (ons_q); start = ONSWT & ~ons_q.
- S_IDLE: PC=0. On start → S_FETCH.
- S_FETCH: synchronous read of mem[PC]. The read data is registered into INSTR on the same edge. Always → S_VALID.
- S_VALID: INSTR_VALID=1, INSTR held stable. On INSTR_VALID & INSTR_READY:
  - INSTR[7:0]==OP_HALT (8'h80) → S_HALT; PC unchanged.
  - else PC==DEPTH-1 → S_HALT; PC unchanged, no wrap.
  - else PC←PC+1 → S_FETCH.
- S_HALT: HALTED=1, INSTR_VALID=0. A new start restarts from PC=0 → S_FETCH.
- OFFSWT=1 in any state → S_IDLE on the next edge. It clears INSTR_VALID, HALTED and PC. OFFSWT beats start and beats the handshake on the same edge.
- PROG_WE is honoured only in S_IDLE or S_HALT. It is silently ignored in S_FETCH/S_VALID.
- A write and a start on the same edge: the write completes, and S_FETCH reads the new contents on the following edge.
- Opcodes other than OP_HALT pass through unchanged; no decoding here.

## Timing
- Reset (async assert, sync-safe deassert): state=S_IDLE, PC_INS=0, INSTR=0, INSTR_VALID=0, FETCH_BUSY=0, HALTED=0, ons_q=0.
- Reset asserted mid-operation: all outputs go to reset values immediately, with no wait for a clock edge.
- Start latency: start sampled at edge k → S_FETCH after k; INSTR_VALID=1 after edge k+1.
- Throughput: one instruction per 2 cycles; handshake at edge j → next INSTR_VALID after edge j+2.
- INSTR_VALID drops for exactly one cycle (S_FETCH) between instructions.
- INSTR_READY while INSTR_VALID=0 has no effect.
- FETCH_BUSY is combinational from state. All other outputs are registered.
- ONSWT held high after HALT does not restart; it must fall and rise again.

## Structure
- Shared package simd_pkg:
  - OP_HALT constant.
  - fetch_state_t enum.
  - IW and the AW derivation, so they are common with the control unit.
- Sub-module instr_mem: DEPTH×IW single-read/single-write synchronous RAM, 1-cycle read latency, BRAM-inferable. FSM, PC and handshake logic live in instr_fetch_unit.

## Test plan
- Load mem[0..3] = 0x01, 0x09, 0x02, 0x80; pulse ONSWT; keep INSTR_READY=1 → INSTR sequence 0x01, 0x09, 0x02, 0x80 with VALID on alternate cycles. After the 0x80 handshake HALTED=1 and PC_INS=3.
- Same program with INSTR_READY=0 for 5 cycles on instruction 0x09 → INSTR holds 0x09, VALID stays 1, PC_INS stays 1. Release → continues with 0x02.
- Fill all 256 words with 0x03 and run → 256 handshakes, then HALTED=1 and PC_INS=255, no wrap to 0.
- OFFSWT pulsed mid-stream at PC=2 → next cycle VALID=0, PC_INS=0, state idle. ONSWT and OFFSWT rising together → stays idle.
- PROG_WE to address 1 (data 0xFF) while in S_VALID → ignored. A rerun reads the original 0x09.
- Async reset asserted between edges during S_VALID → INSTR=0 and VALID=0 before the next edge. After release, a start behaves as after power-up.

Source files
------------

// File: rtl/simd_pkg.sv
// Constants and types shared by the fetch stage and the SIMD control unit.
// Program depth is half the register space; AW is derived from it.
package simd_pkg;

  localparam int REGN  = 512;
  localparam int IW    = 32;
  localparam int DEPTH = REGN / 2;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [7:0] OP_HALT = 8'h80;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: host run/abort/program-load inputs, instruction handshake to
// the control unit, and status. master = fetch unit, slave = host/control side.
interface instr_fetch_unit_if;
  import simd_pkg::*;

  logic          ONSWT;
  logic          OFFSWT;
  logic          PROG_WE;
  logic [AW-1:0] PROG_ADDR;
  logic [IW-1:0] PROG_DATA;
  logic [IW-1:0] INSTR;
  logic          INSTR_VALID;
  logic          INSTR_READY;
  logic [AW-1:0] PC_INS;
  logic          FETCH_BUSY;
  logic          HALTED;

  modport master (
    input  ONSWT, OFFSWT, PROG_WE, PROG_ADDR, PROG_DATA, INSTR_READY,
    output INSTR, INSTR_VALID, PC_INS, FETCH_BUSY, HALTED
  );

  modport slave (
    output ONSWT, OFFSWT, PROG_WE, PROG_ADDR, PROG_DATA, INSTR_READY,
    input  INSTR, INSTR_VALID, PC_INS, FETCH_BUSY, HALTED
  );

endinterface

// File: rtl/instr_fetch_unit_instr_mem.sv
// Program store: single-write/single-read synchronous RAM, 1-cycle read latency.
// The read register only updates when re is high, so rdata holds between reads.
module instr_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int IW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register carries the reset so the instruction bus clears immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: streams program words to the control unit, one per 2 cycles,
// stopping on OP_HALT or at the last address; INSTR holds while INSTR_READY is low.
module instr_fetch_unit
  import simd_pkg::*;
(
  input  logic                CLK,
  input  logic                RSTN,
  instr_fetch_unit_if.master  bus
);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_nxt;
  logic          ons_q;
  logic          start;
  logic          valid_q;
  logic          halted_q;
  logic          mem_we;
  logic          mem_re;
  logic [IW-1:0] rdata;

  assign start  = bus.ONSWT & ~ons_q;
  assign mem_we = bus.PROG_WE & ((state == S_IDLE) || (state == S_HALT));
  assign mem_re = (state == S_FETCH);

  instr_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW)
  ) u_mem (
    .clk   (CLK),
    .rst   (RSTN),
    .we    (mem_we),
    .waddr (bus.PROG_ADDR),
    .wdata (bus.PROG_DATA),
    .re    (mem_re),
    .raddr (pc),
    .rdata (rdata)
  );

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      state    <= S_IDLE;
      pc       <= '0;
      ons_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      ons_q    <= bus.ONSWT;
      valid_q  <= (state_nxt == S_VALID);
      halted_q <= (state_nxt == S_HALT);
    end
  end

  // Abort has priority over start and over an accepting handshake.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (bus.OFFSWT) begin
      state_nxt = S_IDLE;
      pc_nxt    = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          pc_nxt = '0;
          if (start) begin
            state_nxt = S_FETCH;
          end
        end
        S_FETCH: begin
          state_nxt = S_VALID;
        end
        S_VALID: begin
          if (bus.INSTR_READY) begin
            if (rdata[7:0] == OP_HALT) begin
              state_nxt = S_HALT;
            end else if (pc == AW'(DEPTH - 1)) begin
              state_nxt = S_HALT;
            end else begin
              pc_nxt    = pc + AW'(1);
              state_nxt = S_FETCH;
            end
          end
        end
        S_HALT: begin
          if (start) begin
            pc_nxt    = '0;
            state_nxt = S_FETCH;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          pc_nxt    = '0;
        end
      endcase
    end
  end

  assign bus.INSTR       = rdata;
  assign bus.INSTR_VALID = valid_q;
  assign bus.PC_INS      = pc;
  assign bus.HALTED      = halted_q;
  assign bus.FETCH_BUSY  = (state == S_FETCH) || (state == S_VALID);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: program load, streaming, stall, abort,
// write-lockout, end-of-memory halt and asynchronous reset.
module tb_instr_fetch_unit;
  import simd_pkg::*;

  logic CLK;
  logic RSTN;
  int   checks;
  int   failures;
  logic [IW-1:0] prog [DEPTH];

  instr_fetch_unit_if bus ();

  instr_fetch_unit u_dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int addr, input logic [IW-1:0] data);
    bus.PROG_WE   = 1'b1;
    bus.PROG_ADDR = AW'(addr);
    bus.PROG_DATA = data;
    prog[addr]    = data;
    tick();
    bus.PROG_WE   = 1'b0;
  endtask

  // Called one cycle after the start edge; INSTR_READY must be high.
  task automatic stream(input int last);
    for (int i = 0; i <= last; i++) begin
      check("fetch_gap", 32'(bus.INSTR_VALID), 32'd0);
      check("busy", 32'(bus.FETCH_BUSY), 32'd1);
      tick();
      check("valid", 32'(bus.INSTR_VALID), 32'd1);
      check("instr", bus.INSTR, prog[i]);
      check("pc", 32'(bus.PC_INS), 32'(i));
      tick();
    end
    check("halted", 32'(bus.HALTED), 32'd1);
    check("pc_halt", 32'(bus.PC_INS), 32'(last));
    check("valid_halt", 32'(bus.INSTR_VALID), 32'd0);
    check("busy_halt", 32'(bus.FETCH_BUSY), 32'd0);
  endtask

  task automatic start_pulse();
    bus.ONSWT = 1'b1;
    tick();
    bus.ONSWT = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bus.ONSWT = 1'b0;
    bus.OFFSWT = 1'b0;
    bus.PROG_WE = 1'b0;
    bus.PROG_ADDR = '0;
    bus.PROG_DATA = '0;
    bus.INSTR_READY = 1'b0;
    RSTN = 1'b1;
    tick();
    tick();
    check("rst_instr", bus.INSTR, 32'h0);
    check("rst_valid", 32'(bus.INSTR_VALID), 32'd0);
    check("rst_busy", 32'(bus.FETCH_BUSY), 32'd0);
    check("rst_halted", 32'(bus.HALTED), 32'd0);
    check("rst_pc", 32'(bus.PC_INS), 32'd0);
    RSTN = 1'b0;
    tick();

    load(0, 32'h01);
    load(1, 32'h09);
    load(2, 32'h02);
    load(3, 32'h80);

    // Basic run with ONSWT held high: no restart after halt.
    bus.INSTR_READY = 1'b1;
    bus.ONSWT = 1'b1;
    tick();
    stream(3);
    tick();
    tick();
    check("hold_on_halted", 32'(bus.HALTED), 32'd1);
    check("hold_on_busy", 32'(bus.FETCH_BUSY), 32'd0);
    bus.ONSWT = 1'b0;
    tick();

    // Stall on 0x09 with a write attempt that must be ignored.
    start_pulse();
    tick();
    check("st_instr0", bus.INSTR, 32'h01);
    tick();
    bus.INSTR_READY = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("stall_instr", bus.INSTR, 32'h09);
      check("stall_valid", 32'(bus.INSTR_VALID), 32'd1);
      check("stall_pc", 32'(bus.PC_INS), 32'd1);
      bus.PROG_WE   = (k == 1);
      bus.PROG_ADDR = AW'(1);
      bus.PROG_DATA = 32'hFF;
      tick();
    end
    bus.PROG_WE = 1'b0;
    bus.INSTR_READY = 1'b1;
    tick();
    check("rel_gap", 32'(bus.INSTR_VALID), 32'd0);
    check("rel_pc", 32'(bus.PC_INS), 32'd2);
    tick();
    check("rel_instr", bus.INSTR, 32'h02);
    tick();
    tick();
    check("rel_instr3", bus.INSTR, 32'h80);
    tick();
    check("rel_halted", 32'(bus.HALTED), 32'd1);
    check("rel_pc_halt", 32'(bus.PC_INS), 32'd3);

    // Rerun from HALT: mem[1] must still read 0x09.
    start_pulse();
    stream(3);

    // Abort at PC=2 while a handshake is offered.
    start_pulse();
    for (int k = 0; k < 5; k++) tick();
    check("ab_pre_pc", 32'(bus.PC_INS), 32'd2);
    check("ab_pre_valid", 32'(bus.INSTR_VALID), 32'd1);
    bus.OFFSWT = 1'b1;
    tick();
    check("ab_valid", 32'(bus.INSTR_VALID), 32'd0);
    check("ab_pc", 32'(bus.PC_INS), 32'd0);
    check("ab_busy", 32'(bus.FETCH_BUSY), 32'd0);
    check("ab_halted", 32'(bus.HALTED), 32'd0);
    bus.OFFSWT = 1'b0;
    tick();
    bus.OFFSWT = 1'b1;
    bus.ONSWT = 1'b1;
    tick();
    check("both_busy", 32'(bus.FETCH_BUSY), 32'd0);
    tick();
    check("both_busy2", 32'(bus.FETCH_BUSY), 32'd0);
    check("both_valid", 32'(bus.INSTR_VALID), 32'd0);
    bus.OFFSWT = 1'b0;
    bus.ONSWT = 1'b0;
    tick();

    // Fill all of memory with a non-halt opcode: halt at the last address, no wrap.
    for (int a = 0; a < DEPTH; a++) load(a, 32'h03);
    start_pulse();
    stream(DEPTH - 1);
    tick();
    tick();
    check("nowrap_pc", 32'(bus.PC_INS), 32'(DEPTH - 1));
    check("nowrap_halted", 32'(bus.HALTED), 32'd1);

    // Async reset between edges while presenting an instruction.
    start_pulse();
    tick();
    check("ar_pre_valid", 32'(bus.INSTR_VALID), 32'd1);
    check("ar_pre_instr", bus.INSTR, 32'h03);
    #2;
    RSTN = 1'b1;
    #1;
    check("ar_instr", bus.INSTR, 32'h0);
    check("ar_valid", 32'(bus.INSTR_VALID), 32'd0);
    check("ar_pc", 32'(bus.PC_INS), 32'd0);
    check("ar_busy", 32'(bus.FETCH_BUSY), 32'd0);
    check("ar_halted", 32'(bus.HALTED), 32'd0);
    #1;
    RSTN = 1'b0;
    tick();
    start_pulse();
    check("ar_start_busy", 32'(bus.FETCH_BUSY), 32'd1);
    check("ar_start_valid", 32'(bus.INSTR_VALID), 32'd0);
    tick();
    check("ar_run_valid", 32'(bus.INSTR_VALID), 32'd1);
    check("ar_run_instr", bus.INSTR, 32'h03);
    check("ar_run_pc", 32'(bus.PC_INS), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
